pif_xi_arb: RTL and testbench
=============================

PIF_XI_ARB -- requirements
Module: pif_xi_arb

Interface
REQ-001 Parameter AW, default 4, SHALL set the register address width (xi_prwa, rq*_addr).
REQ-002 Parameter DW, default 8, SHALL set the data width (write data, read data, xo_data).
REQ-003 Parameter SW, default 4, SHALL set the read sub-address width.
REQ-004 Parameter READ_LAT, default 5, SHALL set the cycles from address/sub-address stable to valid xo_data.
REQ-005 xclk  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-006 sys_rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-007 rqN_valid  in  1  (N=0,1) SHALL be the requester N transaction request.
REQ-008 rqN_write  in  1  SHALL select write (1) or read (0).
REQ-009 rqN_addr  in  AW  SHALL be the register address.
REQ-010 rqN_sub  in  SW  SHALL be the read sub-address.
REQ-011 rqN_wdata  in  DW  SHALL be the write data.
REQ-012 rqN_ready  out  1  SHALL pulse for one cycle when the request is accepted.
REQ-013 rspN_valid  out  1  SHALL pulse for one cycle when read data is returned.
REQ-014 rspN_rdata  out  DW  SHALL hold the read data; valid when rspN_valid=1.
REQ-015 xi_pwr  out  1  SHALL be the single-cycle register write strobe.
REQ-016 xi_prwa  out  AW  SHALL be the register read/write address.
REQ-017 xi_prdsuba  out  SW  SHALL be the read sub-address.
REQ-018 xi_pd  out  DW  SHALL be the write data.
REQ-019 xi_prdfinished  out  1  SHALL pulse for one cycle at read completion.
REQ-020 xo_data  in  DW  SHALL be the register file readback bus.

Function
REQ-021 FSM states SHALL be IDLE, WRITE, READ_WAIT, READ_DONE.
REQ-022 IDLE: if any rqN_valid, SHALL grant one requester, assert its rqN_ready, latch write/addr/sub/wdata, and go to WRITE or READ_WAIT.
REQ-023 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester not granted last; after reset requester 0 has priority.
REQ-024 A lone request SHALL be granted regardless of the round-robin pointer.
REQ-025 WRITE: SHALL drive xi_pwr=1 for exactly one cycle with the latched xi_prwa/xi_pd, then return to IDLE.
REQ-026 READ_WAIT: SHALL hold xi_prwa/xi_prdsuba for READ_LAT cycles via a down-counter loaded with READ_LAT-1; xi_pwr stays 0.
REQ-027 When the counter reaches 0, SHALL capture xo_data and go to READ_DONE.
REQ-028 READ_DONE: SHALL assert xi_prdfinished and the granted rspN_valid for one cycle with the captured data, then return to IDLE.
REQ-029 Grant-to-response latency for a read SHALL be READ_LAT+2 cycles; a write occupies the bus for 2 cycles including IDLE.
REQ-030 At most one transaction SHALL be in flight; requests arriving while busy SHALL wait, and requesters SHALL hold valid and payload until ready.
REQ-031 xi_prwa, xi_prdsuba and xi_pd SHALL hold their last values in IDLE.
REQ-032 rspN_rdata SHALL hold its last value until the next response to N.
REQ-033 The round-robin pointer SHALL update only on grant.
REQ-034 READ_LAT < 1 SHALL be treated as 1.

Reset
REQ-035 While sys_rst=1, the FSM SHALL be IDLE, the counter 0, and the pointer set to favour requester 0.
REQ-036 While sys_rst=1, all outputs SHALL be 0.
REQ-037 Reset asserted mid-transaction SHALL abort it with no ready, response, strobe or finished pulse.

Structure
REQ-038 The FSM state encoding and the default READ_LAT SHALL live in the shared pif definitions include.
REQ-039 The round-robin arbiter SHALL be a sub-module pif_rr_arb2 (two req inputs, enable, one-hot grant out, registered pointer).

Verification
REQ-040 Write-only: rq0 write addr=3 data=8'h2A -> rq0_ready at T+1, xi_pwr=1 at T+2 with xi_prwa=3 and xi_pd=8'h2A, and xi_pwr=1 for only one cycle.
REQ-041 Read: rq1 read addr=0 sub=1, xo_data model returning 8'h55 after 5 cycles -> rsp1_valid=1 with rsp1_rdata=8'h55 exactly READ_LAT+2 cycles after grant, coincident with xi_prdfinished.
REQ-042 Contention: rq0 and rq1 both valid continuously with 4 writes each -> grants alternate 0,1,0,1…, with no back-to-back grants to the same requester.
REQ-043 Busy: rq0 requests during rq1's READ_WAIT -> rq0_ready is not asserted until the cycle after READ_DONE.
REQ-044 Reset mid-read: sys_rst pulsed during READ_WAIT -> all outputs are 0, no rsp pulse, and the next request after reset completes normally.

Source files
------------

// File: rtl/pif_xi_arb_pkg.sv
// Shared definitions for the PIF register-interface arbiter.
//   pif_state_t          : transaction FSM state encoding
//   PIF_READ_LAT_DEFAULT : default address-to-readback latency in cycles
//   pif_eff_lat()        : clamps a latency parameter to a minimum of 1
package pif_xi_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITE     = 2'd1,
      ST_READ_WAIT = 2'd2,
      ST_READ_DONE = 2'd3
   } pif_state_t;

   localparam int PIF_READ_LAT_DEFAULT = 5;

   function automatic int pif_eff_lat(input int lat);
      return (lat < 1) ? 1 : lat;
   endfunction

endpackage

// File: rtl/pif_xi_arb_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   req[1:0] : request lines
//   en       : grant allowed this cycle
//   gnt[1:0] : one-hot grant (combinational from req, en and the pointer)
// The pointer records which requester wins a tie next; it moves only when
// a grant is actually issued, and a lone request always wins.
module pif_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt
);

   logic favour1_q;

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req == 2'b11) gnt = favour1_q ? 2'b10 : 2'b01;
         else              gnt = req;
      end
   end

   // After granting requester 0, requester 1 wins the next tie, and vice versa.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       favour1_q <= 1'b0;
      else if (|gnt) favour1_q <= gnt[0];
   end

endmodule

// File: rtl/pif_xi_arb.sv
// Arbitrates two requesters onto a single PIF register port.
//   xclk, sys_rst            : clock, asynchronous active-high reset
//   rqN_valid/write/addr/sub/wdata, rqN_ready : requester N request side
//   rspN_valid, rspN_rdata   : requester N read response
//   xi_pwr, xi_prwa, xi_prdsuba, xi_pd, xi_prdfinished : register port
//   xo_data                  : register file readback bus
//   state_dbg                : current FSM state
// Handshake: a requester holds rqN_valid and its payload until it sees the
// one-cycle rqN_ready pulse; the pulse appears the cycle after the grant
// decision, by which time the FSM is already busy with that transaction.
// All outputs are registered so they are clean and zero throughout reset.
module pif_xi_arb
   import pif_xi_arb_pkg::*;
#(
   parameter int AW       = 4,
   parameter int DW       = 8,
   parameter int SW       = 4,
   parameter int READ_LAT = PIF_READ_LAT_DEFAULT
) (
   input  logic          xclk,
   input  logic          sys_rst,
   input  logic          rq0_valid,
   input  logic          rq0_write,
   input  logic [AW-1:0] rq0_addr,
   input  logic [SW-1:0] rq0_sub,
   input  logic [DW-1:0] rq0_wdata,
   output logic          rq0_ready,
   input  logic          rq1_valid,
   input  logic          rq1_write,
   input  logic [AW-1:0] rq1_addr,
   input  logic [SW-1:0] rq1_sub,
   input  logic [DW-1:0] rq1_wdata,
   output logic          rq1_ready,
   output logic          rsp0_valid,
   output logic [DW-1:0] rsp0_rdata,
   output logic          rsp1_valid,
   output logic [DW-1:0] rsp1_rdata,
   output logic          xi_pwr,
   output logic [AW-1:0] xi_prwa,
   output logic [SW-1:0] xi_prdsuba,
   output logic [DW-1:0] xi_pd,
   output logic          xi_prdfinished,
   input  logic [DW-1:0] xo_data,
   output logic [1:0]    state_dbg
);

   localparam int LAT_EFF = pif_eff_lat(READ_LAT);
   localparam int CW      = (LAT_EFF > 1) ? $clog2(LAT_EFF) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(LAT_EFF - 1);

   pif_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic [1:0]    gnt;
   logic          gid_q;
   logic          sel_write;
   logic          pwr_d, fin_d;
   logic [1:0]    rsp_valid_d;
   logic [DW-1:0] cap_q;
   logic [1:0]    ready_q, rsp_valid_q;
   logic          pwr_q, fin_q;
   logic [AW-1:0] addr_q;
   logic [SW-1:0] sub_q;
   logic [DW-1:0] pd_q;
   logic [DW-1:0] rdata0_q, rdata1_q;

   pif_rr_arb2 u_arb (
      .clk (xclk),
      .rst (sys_rst),
      .req ({rq1_valid, rq0_valid}),
      .en  (state_q == ST_IDLE),
      .gnt (gnt)
   );

   assign sel_write = gnt[1] ? rq1_write : rq0_write;

   // State register
   always_ff @(posedge xclk or posedge sys_rst) begin
      if (sys_rst) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:      if (|gnt) state_d = sel_write ? ST_WRITE : ST_READ_WAIT;
         ST_WRITE:     state_d = ST_IDLE;
         ST_READ_WAIT: if (cnt_q == '0) state_d = ST_READ_DONE;
         ST_READ_DONE: state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // Output decode; the pulses are registered below, so each one lands in
   // the cycle after the state that requests it.
   always_comb begin
      pwr_d       = 1'b0;
      fin_d       = 1'b0;
      rsp_valid_d = 2'b00;
      unique case (state_q)
         ST_WRITE:     pwr_d = 1'b1;
         ST_READ_DONE: begin
            fin_d       = 1'b1;
            rsp_valid_d = gid_q ? 2'b10 : 2'b01;
         end
         default: ;
      endcase
   end

   always_ff @(posedge xclk or posedge sys_rst) begin
      if (sys_rst) begin
         ready_q     <= '0;
         rsp_valid_q <= '0;
         pwr_q       <= 1'b0;
         fin_q       <= 1'b0;
         gid_q       <= 1'b0;
         addr_q      <= '0;
         sub_q       <= '0;
         pd_q        <= '0;
         cnt_q       <= '0;
         cap_q       <= '0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
      end else begin
         ready_q     <= gnt;
         rsp_valid_q <= rsp_valid_d;
         pwr_q       <= pwr_d;
         fin_q       <= fin_d;
         // Port address/data are only updated on grant, so they hold in IDLE.
         if (|gnt) begin
            gid_q  <= gnt[1];
            addr_q <= gnt[1] ? rq1_addr  : rq0_addr;
            sub_q  <= gnt[1] ? rq1_sub   : rq0_sub;
            pd_q   <= gnt[1] ? rq1_wdata : rq0_wdata;
         end
         if ((|gnt) && !sel_write)
            cnt_q <= CNT_LOAD;
         else if (state_q == ST_READ_WAIT && cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
         // The address has been stable LAT_EFF cycles when the count hits 0.
         if (state_q == ST_READ_WAIT && cnt_q == '0)
            cap_q <= xo_data;
         if (fin_d) begin
            if (gid_q) rdata1_q <= cap_q;
            else       rdata0_q <= cap_q;
         end
      end
   end

   assign rq0_ready      = ready_q[0];
   assign rq1_ready      = ready_q[1];
   assign rsp0_valid     = rsp_valid_q[0];
   assign rsp1_valid     = rsp_valid_q[1];
   assign rsp0_rdata     = rdata0_q;
   assign rsp1_rdata     = rdata1_q;
   assign xi_pwr         = pwr_q;
   assign xi_prwa        = addr_q;
   assign xi_prdsuba     = sub_q;
   assign xi_pd          = pd_q;
   assign xi_prdfinished = fin_q;
   assign state_dbg      = state_q;

endmodule

// File: tb/tb_pif_xi_arb.sv
module tb_pif_xi_arb;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int SW = 4;
   localparam int READ_LAT = 5;

   // ---------------- clock / reset ----------------
   logic xclk = 1'b0;
   logic sys_rst;
   int   cyc = 0;
   always #5 xclk = ~xclk;
   always @(posedge xclk) cyc++;

   logic          rq_valid[2];
   logic          rq_write[2];
   logic [AW-1:0] rq_addr[2];
   logic [SW-1:0] rq_sub[2];
   logic [DW-1:0] rq_wdata[2];
   logic          rq_ready[2];
   logic          rsp0_valid, rsp1_valid;
   logic [DW-1:0] rsp0_rdata, rsp1_rdata;
   logic          xi_pwr, xi_prdfinished;
   logic [AW-1:0] xi_prwa;
   logic [SW-1:0] xi_prdsuba;
   logic [DW-1:0] xi_pd;
   logic [DW-1:0] xo_data;
   logic [1:0]    state_dbg;

   pif_xi_arb #(.AW(AW), .DW(DW), .SW(SW), .READ_LAT(READ_LAT)) dut (
      .xclk(xclk), .sys_rst(sys_rst),
      .rq0_valid(rq_valid[0]), .rq0_write(rq_write[0]), .rq0_addr(rq_addr[0]),
      .rq0_sub(rq_sub[0]), .rq0_wdata(rq_wdata[0]), .rq0_ready(rq_ready[0]),
      .rq1_valid(rq_valid[1]), .rq1_write(rq_write[1]), .rq1_addr(rq_addr[1]),
      .rq1_sub(rq_sub[1]), .rq1_wdata(rq_wdata[1]), .rq1_ready(rq_ready[1]),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .xi_pwr(xi_pwr), .xi_prwa(xi_prwa), .xi_prdsuba(xi_prdsuba), .xi_pd(xi_pd),
      .xi_prdfinished(xi_prdfinished), .xo_data(xo_data), .state_dbg(state_dbg)
   );

   // ---------------- register file readback model ----------------
   // Returns real data only once address/sub-address have been stable for
   // READ_LAT cycles; a premature capture sees 8'hEE.
   function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a, input logic [SW-1:0] s);
      return {a, s} ^ 8'h54;
   endfunction

   logic [AW+SW-1:0] last_as = '0;
   int stab = 0;
   always @(negedge xclk) begin
      if ({xi_prwa, xi_prdsuba} !== last_as) begin
         last_as = {xi_prwa, xi_prdsuba};
         stab = 1;
      end else if (stab < 1000) begin
         stab = stab + 1;
      end
   end
   assign xo_data = (stab >= READ_LAT) ? rd_val(xi_prwa, xi_prdsuba) : 8'hEE;

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [0:0]     exp_gnt_q[$];
   logic [AW+DW-1:0] exp_wr_q0[$], exp_wr_q1[$];
   logic [DW-1:0]  exp_rsp_q0[$], exp_rsp_q1[$];
   int ready_cyc[2] = '{-1, -1};
   int rsp_cyc[2]   = '{-1, -1};
   int pwr_cyc = -1;
   logic cur_id = 1'b0;
   logic prev_pwr = 1'b0;

   always @(negedge xclk) begin
      logic [0:0] e_id;
      logic [AW+DW-1:0] e_wr;
      logic [DW-1:0] e_rd;
      logic got_id;
      if (sys_rst) begin
         prev_pwr = 1'b0;
      end else begin
         if (rq_ready[0] || rq_ready[1]) begin
            got_id = rq_ready[1];
            checks++;
            assert (!(rq_ready[0] && rq_ready[1])) else begin
               errors++; $error("FAIL gnt_onehot obs=11 exp=one_hot");
            end
            checks++;
            assert (exp_gnt_q.size() != 0) else begin
               errors++; $error("FAIL gnt_unexpected obs=%0d exp=none", got_id);
            end
            if (exp_gnt_q.size() != 0) begin
               e_id = exp_gnt_q.pop_front();
               checks++;
               assert (got_id === e_id[0]) else begin
                  errors++; $error("FAIL gnt_order obs=%0d exp=%0d", got_id, e_id);
               end
            end
            cur_id = got_id;
            ready_cyc[int'(got_id)] = cyc;
         end
         if (xi_pwr) begin
            pwr_cyc = cyc;
            checks++;
            assert (!prev_pwr) else begin
               errors++; $error("FAIL pwr_single obs=2cycles exp=1cycle");
            end
            checks++;
            assert ((cur_id ? exp_wr_q1.size() : exp_wr_q0.size()) != 0) else begin
               errors++; $error("FAIL wr_unexpected obs=%0h exp=none", {xi_prwa, xi_pd});
            end
            if ((cur_id ? exp_wr_q1.size() : exp_wr_q0.size()) != 0) begin
               e_wr = cur_id ? exp_wr_q1.pop_front() : exp_wr_q0.pop_front();
               checks++;
               assert ({xi_prwa, xi_pd} === e_wr) else begin
                  errors++; $error("FAIL wr_data obs=%0h exp=%0h", {xi_prwa, xi_pd}, e_wr);
               end
            end
         end
         if (xi_prdfinished) begin
            checks++;
            assert (rsp0_valid || rsp1_valid) else begin
               errors++; $error("FAIL fin_without_rsp obs=0 exp=1");
            end
         end
         if (rsp0_valid) begin
            rsp_cyc[0] = cyc;
            checks++;
            assert (xi_prdfinished === 1'b1) else begin
               errors++; $error("FAIL rsp0_fin obs=%0b exp=1", xi_prdfinished);
            end
            checks++;
            assert (cyc - ready_cyc[0] == READ_LAT + 1) else begin
               errors++; $error("FAIL rsp0_lat obs=%0d exp=%0d", cyc - ready_cyc[0], READ_LAT + 1);
            end
            checks++;
            assert (exp_rsp_q0.size() != 0) else begin
               errors++; $error("FAIL rsp0_unexpected obs=%0h exp=none", rsp0_rdata);
            end
            if (exp_rsp_q0.size() != 0) begin
               e_rd = exp_rsp_q0.pop_front();
               checks++;
               assert (rsp0_rdata === e_rd) else begin
                  errors++; $error("FAIL rsp0_data obs=%0h exp=%0h", rsp0_rdata, e_rd);
               end
            end
         end
         if (rsp1_valid) begin
            rsp_cyc[1] = cyc;
            checks++;
            assert (xi_prdfinished === 1'b1) else begin
               errors++; $error("FAIL rsp1_fin obs=%0b exp=1", xi_prdfinished);
            end
            checks++;
            assert (cyc - ready_cyc[1] == READ_LAT + 1) else begin
               errors++; $error("FAIL rsp1_lat obs=%0d exp=%0d", cyc - ready_cyc[1], READ_LAT + 1);
            end
            checks++;
            assert (exp_rsp_q1.size() != 0) else begin
               errors++; $error("FAIL rsp1_unexpected obs=%0h exp=none", rsp1_rdata);
            end
            if (exp_rsp_q1.size() != 0) begin
               e_rd = exp_rsp_q1.pop_front();
               checks++;
               assert (rsp1_rdata === e_rd) else begin
                  errors++; $error("FAIL rsp1_data obs=%0h exp=%0h", rsp1_rdata, e_rd);
               end
            end
         end
         prev_pwr = xi_pwr;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input int n, input logic wr, input logic [AW-1:0] a,
                        input logic [SW-1:0] s, input logic [DW-1:0] d, output int t_set);
      bit got = 0;
      @(posedge xclk); #1;
      rq_valid[n] = 1'b1; rq_write[n] = wr; rq_addr[n] = a; rq_sub[n] = s; rq_wdata[n] = d;
      t_set = cyc;
      if (wr) begin
         if (n == 0) exp_wr_q0.push_back({a, d}); else exp_wr_q1.push_back({a, d});
      end else begin
         if (n == 0) exp_rsp_q0.push_back(rd_val(a, s)); else exp_rsp_q1.push_back(rd_val(a, s));
      end
      for (int i = 0; i < 100; i++) begin
         @(posedge xclk); #1;
         if (rq_ready[n]) begin got = 1; break; end
      end
      checks++;
      assert (got) else begin
         errors++; $error("FAIL ready_timeout rq%0d obs=0 exp=1", n);
      end
      rq_valid[n] = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      logic [39:0] v;
      v = {rq_ready[0], rq_ready[1], rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
           xi_pwr, xi_prwa, xi_prdsuba, xi_pd, xi_prdfinished, state_dbg};
      checks++;
      assert (v === '0) else begin
         errors++; $error("FAIL %s obs=%0h exp=0", tag, v);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs == exp) else begin
         errors++; $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int t0, t1, tdummy;
      sys_rst = 1'b1;
      for (int n = 0; n < 2; n++) begin
         rq_valid[n] = 1'b0; rq_write[n] = 1'b0; rq_addr[n] = '0; rq_sub[n] = '0; rq_wdata[n] = '0;
      end
      repeat (2) @(posedge xclk);
      #1 chk_zero("reset_outputs");
      @(negedge xclk) sys_rst = 1'b0;

      // Lone write from rq0
      exp_gnt_q.push_back(1'b0);
      issue(0, 1'b1, 4'd3, 4'd0, 8'h2A, t0);
      repeat (3) @(posedge xclk);
      chk_int("wr_ready_time", ready_cyc[0], t0 + 1);
      chk_int("wr_pwr_time", pwr_cyc, t0 + 2);

      // Lone read from rq1
      exp_gnt_q.push_back(1'b1);
      issue(1, 1'b0, 4'd0, 4'd1, 8'h00, t0);
      repeat (READ_LAT + 4) @(posedge xclk);
      chk_int("rd_rsp_time", rsp_cyc[1], t0 + READ_LAT + 2);

      // Contention: both stream 4 writes, grants alternate starting with 0
      for (int i = 0; i < 4; i++) begin
         exp_gnt_q.push_back(1'b0);
         exp_gnt_q.push_back(1'b1);
      end
      fork
         begin
            int t;
            for (int i = 0; i < 4; i++) issue(0, 1'b1, 4'(4 + i), 4'd0, 8'(8'h10 + i), t);
         end
         begin
            int t;
            for (int i = 0; i < 4; i++) issue(1, 1'b1, 4'(8 + i), 4'd0, 8'(8'h80 + i), t);
         end
      join
      repeat (3) @(posedge xclk);

      // Busy: rq0 arrives during rq1's read wait
      exp_gnt_q.push_back(1'b1);
      exp_gnt_q.push_back(1'b0);
      fork
         issue(1, 1'b0, 4'd5, 4'd2, 8'h00, t0);
         begin
            repeat (3) @(posedge xclk);
            issue(0, 1'b1, 4'd6, 4'd0, 8'h77, t1);
         end
      join
      repeat (3) @(posedge xclk);
      chk_int("busy_ready_after_rsp", ready_cyc[0], rsp_cyc[1] + 1);

      // Reset mid-read: the aborted read must never respond
      exp_gnt_q.push_back(1'b0);
      issue(0, 1'b0, 4'd7, 4'd3, 8'h00, t0);
      repeat (2) @(posedge xclk);
      void'(exp_rsp_q0.pop_back());
      #3 sys_rst = 1'b1;
      #1 chk_zero("rst_async_outputs");
      repeat (2) @(posedge xclk);
      #1 chk_zero("rst_hold_outputs");
      @(negedge xclk) sys_rst = 1'b0;

      // Pointer reset to favour 0 even though 0 was granted last
      exp_gnt_q.push_back(1'b0);
      exp_gnt_q.push_back(1'b1);
      fork
         issue(0, 1'b1, 4'd1, 4'd0, 8'hC3, tdummy);
         issue(1, 1'b1, 4'd9, 4'd0, 8'h3C, t1);
      join
      repeat (3) @(posedge xclk);

      // Normal read after reset
      exp_gnt_q.push_back(1'b1);
      issue(1, 1'b0, 4'd2, 4'd4, 8'h00, t0);
      repeat (READ_LAT + 4) @(posedge xclk);
      chk_int("post_rst_rsp_time", rsp_cyc[1], t0 + READ_LAT + 2);

      chk_int("sb_drain", exp_gnt_q.size() + exp_wr_q0.size() + exp_wr_q1.size()
              + exp_rsp_q0.size() + exp_rsp_q1.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
